// File: rtl/alu_mc.sv
// Multi-cycle ALU with a valid/ready handshake on both sides.
// Add/sub/logic/slt finish in one cycle; shifts step one bit per cycle.
module alu_mc #(
   parameter int N = 8
) (
   input  logic         i_clk,
   input  logic         i_rst,
   input  logic         i_valid,
   output logic         o_ready,
   input  logic [N-1:0] i_a,
   input  logic [N-1:0] i_b,
   input  logic [2:0]   i_alu_ctrl,
   output logic         o_valid,
   input  logic         i_ready,
   output logic [N-1:0] o_result,
   output logic         o_carry_out,
   output logic         o_overflow,
   output logic         o_zero,
   output logic         o_negative
);

   localparam int SW = $clog2(N);

   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_SUB = 3'b001;
   localparam logic [2:0] OP_AND = 3'b010;
   localparam logic [2:0] OP_OR  = 3'b011;
   localparam logic [2:0] OP_SLT = 3'b100;
   localparam logic [2:0] OP_SLL = 3'b101;
   localparam logic [2:0] OP_SRL = 3'b110;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t        state_reg, state_next;
   logic [SW-1:0] cnt_reg, cnt_next;
   logic [N-1:0]  work_reg, work_next;
   logic [2:0]    op_reg, op_next;
   logic [N-1:0]  result_reg, result_next;
   logic          carry_reg, carry_next;
   logic          ovf_reg, ovf_next;
   logic          zero_reg, zero_next;
   logic          neg_reg, neg_next;

   // Issue-side single-cycle datapath, evaluated on the live inputs at accept.
   logic          is_sub;
   logic          is_shift;
   logic [N-1:0]  b_eff;
   logic [N:0]    sum;
   logic          add_ovf;
   logic          slt_bit;
   logic [SW-1:0] shamt;
   logic [N-1:0]  alu_result;
   logic          alu_carry;
   logic          alu_ovf;

   assign is_sub   = (i_alu_ctrl == OP_SUB) || (i_alu_ctrl == OP_SLT);
   assign is_shift = i_alu_ctrl[2] && (i_alu_ctrl[1:0] != 2'b00);
   assign b_eff    = is_sub ? ~i_b : i_b;
   assign sum      = {1'b0, i_a} + {1'b0, b_eff} + {{N{1'b0}}, is_sub};
   assign add_ovf  = (i_a[N-1] == b_eff[N-1]) && (sum[N-1] != i_a[N-1]);
   assign slt_bit  = sum[N-1] ^ add_ovf;
   assign shamt    = i_b[SW-1:0];

   always_comb begin
      alu_result = i_a;
      alu_carry  = 1'b0;
      alu_ovf    = 1'b0;
      case (i_alu_ctrl)
         OP_ADD, OP_SUB: begin
            alu_result = sum[N-1:0];
            alu_carry  = sum[N];
            alu_ovf    = add_ovf;
         end
         OP_AND: alu_result = i_a & i_b;
         OP_OR:  alu_result = i_a | i_b;
         OP_SLT: begin
            alu_result = {{(N-1){1'b0}}, slt_bit};
            alu_carry  = sum[N];
            alu_ovf    = add_ovf;
         end
         default: ; // zero-amount shift passes operand A through
      endcase
   end

   // One-bit shift network on the working register.
   logic [N-1:0] sll_one;
   logic [N-1:0] srl_one;
   logic [N-1:0] sra_one;
   logic [N-1:0] shift_one;
   logic         shift_out;

   genvar gi;
   generate
      for (gi = 0; gi < N; gi++) begin : g_shift
         if (gi == 0) begin : g_lsb
            assign sll_one[gi] = 1'b0;
         end else begin : g_lsl
            assign sll_one[gi] = work_reg[gi-1];
         end
         if (gi == N-1) begin : g_msb
            assign srl_one[gi] = 1'b0;
            assign sra_one[gi] = work_reg[N-1];
         end else begin : g_lsr
            assign srl_one[gi] = work_reg[gi+1];
            assign sra_one[gi] = work_reg[gi+1];
         end
      end
   endgenerate

   always_comb begin
      shift_one = sra_one;
      shift_out = work_reg[0];
      if (op_reg == OP_SLL) begin
         shift_one = sll_one;
         shift_out = work_reg[N-1];
      end else if (op_reg == OP_SRL) begin
         shift_one = srl_one;
      end
   end

   assign o_ready = (state_reg == IDLE) && !i_rst;

   always_comb begin
      state_next  = state_reg;
      cnt_next    = cnt_reg;
      work_next   = work_reg;
      op_next     = op_reg;
      result_next = result_reg;
      carry_next  = carry_reg;
      ovf_next    = ovf_reg;
      zero_next   = zero_reg;
      neg_next    = neg_reg;
      case (state_reg)
         IDLE: begin
            if (i_valid && o_ready) begin
               if (is_shift && (shamt != '0)) begin
                  work_next  = i_a;
                  cnt_next   = shamt;
                  op_next    = i_alu_ctrl;
                  state_next = SHIFT;
               end else begin
                  result_next = alu_result;
                  carry_next  = alu_carry;
                  ovf_next    = alu_ovf;
                  zero_next   = (alu_result == '0);
                  neg_next    = alu_result[N-1];
                  state_next  = DONE;
               end
            end
         end
         SHIFT: begin
            work_next = shift_one;
            cnt_next  = cnt_reg - SW'(1);
            // Final step: publish the shifted value in the same edge the count hits zero.
            if (cnt_reg == SW'(1)) begin
               result_next = shift_one;
               carry_next  = shift_out;
               ovf_next    = 1'b0;
               zero_next   = (shift_one == '0);
               neg_next    = shift_one[N-1];
               state_next  = DONE;
            end
         end
         DONE: begin
            if (i_ready) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_reg  <= IDLE;
         cnt_reg    <= '0;
         work_reg   <= '0;
         op_reg     <= '0;
         result_reg <= '0;
         carry_reg  <= 1'b0;
         ovf_reg    <= 1'b0;
         zero_reg   <= 1'b0;
         neg_reg    <= 1'b0;
      end else begin
         state_reg  <= state_next;
         cnt_reg    <= cnt_next;
         work_reg   <= work_next;
         op_reg     <= op_next;
         result_reg <= result_next;
         carry_reg  <= carry_next;
         ovf_reg    <= ovf_next;
         zero_reg   <= zero_next;
         neg_reg    <= neg_next;
      end
   end

   assign o_valid     = (state_reg == DONE);
   assign o_result    = result_reg;
   assign o_carry_out = carry_reg;
   assign o_overflow  = ovf_reg;
   assign o_zero      = zero_reg;
   assign o_negative  = neg_reg;

endmodule

// File: tb/tb_alu_mc.sv
// Directed-vector bench for alu_mc (N = 8) with hand-computed expectations.
module tb_alu_mc;

   localparam int N = 8;

   logic         i_clk = 1'b0;
   logic         i_rst;
   logic         i_valid;
   logic         o_ready;
   logic [N-1:0] i_a;
   logic [N-1:0] i_b;
   logic [2:0]   i_alu_ctrl;
   logic         o_valid;
   logic         i_ready;
   logic [N-1:0] o_result;
   logic         o_carry_out;
   logic         o_overflow;
   logic         o_zero;
   logic         o_negative;

   int errors = 0;
   int checks = 0;

   always #5 i_clk = ~i_clk;

   alu_mc #(.N(N)) dut (
      .i_clk       (i_clk),
      .i_rst       (i_rst),
      .i_valid     (i_valid),
      .o_ready     (o_ready),
      .i_a         (i_a),
      .i_b         (i_b),
      .i_alu_ctrl  (i_alu_ctrl),
      .o_valid     (o_valid),
      .i_ready     (i_ready),
      .o_result    (o_result),
      .o_carry_out (o_carry_out),
      .o_overflow  (o_overflow),
      .o_zero      (o_zero),
      .o_negative  (o_negative)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Issue one op from a negedge, wait for o_valid, check result, flags and latency.
   task automatic run_op(input string tag, input logic [2:0] op, input logic [7:0] a,
                         input logic [7:0] b, input logic [7:0] er, input logic ec,
                         input logic ev, input int el);
      int lat;
      chk({tag, ".ready"}, 32'(o_ready), 32'd1);
      i_valid    = 1'b1;
      i_a        = a;
      i_b        = b;
      i_alu_ctrl = op;
      lat        = 0;
      do begin
         @(negedge i_clk);
         lat++;
         if (lat == 1) begin
            i_valid    = 1'b0;
            i_a        = ~a;
            i_b        = ~b;
            i_alu_ctrl = ~op;
         end
      end while (!o_valid && lat < 20);
      chk({tag, ".latency"}, 32'(lat), 32'(el));
      chk({tag, ".result"}, 32'(o_result), 32'(er));
      chk({tag, ".carry"}, 32'(o_carry_out), 32'(ec));
      chk({tag, ".overflow"}, 32'(o_overflow), 32'(ev));
      chk({tag, ".zero"}, 32'(o_zero), 32'(er == 8'h00));
      chk({tag, ".negative"}, 32'(o_negative), 32'(er[7]));
      $display("%s: op=%b a=%h b=%h -> result=%h c=%b v=%b z=%b n=%b lat=%0d",
               tag, op, a, b, o_result, o_carry_out, o_overflow, o_zero, o_negative, lat);
   endtask

   task automatic release_result(input string tag);
      i_ready = 1'b1;
      @(negedge i_clk);
      i_ready = 1'b0;
      chk({tag, ".valid_drop"}, 32'(o_valid), 32'd0);
      chk({tag, ".ready_back"}, 32'(o_ready), 32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      i_rst      = 1'b1;
      i_valid    = 1'b0;
      i_ready    = 1'b0;
      i_a        = '0;
      i_b        = '0;
      i_alu_ctrl = 3'b000;
      repeat (3) @(negedge i_clk);
      chk("rst.ready", 32'(o_ready), 32'd0);
      chk("rst.valid", 32'(o_valid), 32'd0);
      chk("rst.result", 32'(o_result), 32'd0);
      chk("rst.carry", 32'(o_carry_out), 32'd0);
      chk("rst.overflow", 32'(o_overflow), 32'd0);
      chk("rst.zero", 32'(o_zero), 32'd0);
      chk("rst.negative", 32'(o_negative), 32'd0);
      $display("reset: ready=%b valid=%b result=%h", o_ready, o_valid, o_result);
      i_rst = 1'b0;
      @(negedge i_clk);
      chk("rst.ready_after", 32'(o_ready), 32'd1);

      run_op("add", 3'b000, 8'hBD, 8'hA5, 8'h62, 1'b1, 1'b1, 1);
      release_result("add");
      run_op("sub", 3'b001, 8'hBD, 8'hA5, 8'h18, 1'b1, 1'b0, 1);
      release_result("sub");
      run_op("and", 3'b010, 8'hF0, 8'h0F, 8'h00, 1'b0, 1'b0, 1);
      release_result("and");
      run_op("or", 3'b011, 8'h12, 8'h40, 8'h52, 1'b0, 1'b0, 1);
      release_result("or");
      run_op("slt_ovf", 3'b100, 8'h80, 8'h01, 8'h01, 1'b1, 1'b1, 1);
      release_result("slt_ovf");
      run_op("slt_neg", 3'b100, 8'h01, 8'h80, 8'h00, 1'b0, 1'b1, 1);
      release_result("slt_neg");
      run_op("sra3", 3'b111, 8'h94, 8'h03, 8'hF2, 1'b1, 1'b0, 4);
      release_result("sra3");
      run_op("sll0", 3'b101, 8'h5A, 8'h08, 8'h5A, 1'b0, 1'b0, 1);
      release_result("sll0");
      run_op("srl1", 3'b110, 8'h81, 8'h01, 8'h40, 1'b1, 1'b0, 2);
      release_result("srl1");
      run_op("sll7", 3'b101, 8'h81, 8'h07, 8'h80, 1'b0, 1'b0, 8);
      release_result("sll7");

      // Backpressure: result must hold and new requests must be ignored.
      run_op("bp_add", 3'b000, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1, 1);
      for (int i = 0; i < 3; i++) begin
         i_valid    = (i % 2 == 0);
         i_a        = 8'h33;
         i_b        = 8'h44;
         i_alu_ctrl = 3'b011;
         @(negedge i_clk);
         chk("bp.valid", 32'(o_valid), 32'd1);
         chk("bp.result", 32'(o_result), 32'h80);
         chk("bp.carry", 32'(o_carry_out), 32'd0);
         chk("bp.overflow", 32'(o_overflow), 32'd1);
         chk("bp.negative", 32'(o_negative), 32'd1);
         chk("bp.ready", 32'(o_ready), 32'd0);
         $display("bp cycle %0d: valid=%b ready=%b result=%h", i, o_valid, o_ready, o_result);
      end
      i_valid = 1'b0;
      release_result("bp");
      @(negedge i_clk);
      chk("bp.no_ghost", 32'(o_valid), 32'd0);

      // Reset in the middle of a 7-step shift.
      chk("rs.ready", 32'(o_ready), 32'd1);
      i_valid    = 1'b1;
      i_a        = 8'hFF;
      i_b        = 8'h07;
      i_alu_ctrl = 3'b110;
      @(negedge i_clk);
      i_valid = 1'b0;
      chk("rs.held_result", 32'(o_result), 32'h80);
      chk("rs.shift_valid", 32'(o_valid), 32'd0);
      chk("rs.shift_ready", 32'(o_ready), 32'd0);
      repeat (2) @(negedge i_clk);
      i_rst = 1'b1;
      @(negedge i_clk);
      chk("rs.valid", 32'(o_valid), 32'd0);
      chk("rs.result", 32'(o_result), 32'd0);
      chk("rs.carry", 32'(o_carry_out), 32'd0);
      chk("rs.overflow", 32'(o_overflow), 32'd0);
      chk("rs.zero", 32'(o_zero), 32'd0);
      chk("rs.negative", 32'(o_negative), 32'd0);
      chk("rs.ready_in_rst", 32'(o_ready), 32'd0);
      $display("reset mid-shift: valid=%b result=%h", o_valid, o_result);
      i_rst = 1'b0;
      @(negedge i_clk);
      chk("rs.ready_after", 32'(o_ready), 32'd1);
      chk("rs.valid_after", 32'(o_valid), 32'd0);
      run_op("post_rst_add", 3'b000, 8'h01, 8'h01, 8'h02, 1'b0, 1'b0, 1);
      release_result("post_rst_add");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
